sha256_padder: RTL



---
 rtl/sha256_pkg.sv | 32 +++
 rtl/sha256_padder.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/sha256_pkg.sv
// Shared types, constants and the last-word padding helper for the SHA-256 message padder.
// The 64-bit length counter width is fixed here so the padder and any consumer agree on it.
package sha256_pkg;

  localparam int          LenWidth   = 64;
  localparam int          BlockWords = 16;
  localparam logic [31:0] PadWord    = 32'h8000_0000;

  typedef enum logic [1:0] {
    ABSORB    = 2'd0,
    PAD       = 2'd1,
    EMIT      = 2'd2,
    EMIT_LAST = 2'd3
  } sha_pad_fsm_e;

  // Keep the first nbytes message bytes, put 0x80 right after them and zero the rest.
  // nbytes >= 4 leaves the word untouched; the 0x80 then goes into the following word.
  function automatic logic [31:0] pad_last_word(input logic [31:0] word,
                                                input logic [2:0]  nbytes);
    logic [31:0] res;
    res = word;
    case (nbytes)
      3'd0:    res = PadWord;
      3'd1:    res = {word[31:24], 24'h80_0000};
      3'd2:    res = {word[31:16], 16'h8000};
      3'd3:    res = {word[31:8], 8'h80};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sha256_padder.sv
// FIPS 180-4 message padder: packs a big-endian 32-bit word stream into 512-bit blocks,
// appends 0x80, zero fill and the 64-bit bit length, and tags the final block of each message.
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int BlockWidth = 512,
  parameter int WordWidth  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [WordWidth-1:0]  data_i,
  input  logic                  data_valid_i,
  output logic                  data_ready_o,
  input  logic                  data_last_i,
  input  logic [2:0]            data_bytes_i,
  output logic [BlockWidth-1:0] block_o,
  output logic                  block_valid_o,
  input  logic                  block_ready_i,
  output logic                  block_last_o,
  output logic                  busy_o,
  output sha_pad_fsm_e          state_o
);

  // Both ports use strict valid/ready: a transfer happens on a rising edge where valid and
  // ready are both high; a producer holding valid keeps its payload stable until that edge.

  sha_pad_fsm_e         r_state;
  sha_pad_fsm_e         w_state_nxt;
  logic [WordWidth-1:0] r_buf [BlockWords];
  logic [4:0]           r_word_cntr;
  logic [3:0]           w_idx;
  logic [LenWidth-1:0]  r_len;
  logic [LenWidth-1:0]  w_len_inc;
  logic                 r_pad80_pending;
  logic                 r_padding_q;
  logic                 w_accept;
  logic [2:0]           w_nbytes;
  logic [WordWidth-1:0] w_wr_word;

  assign w_idx     = r_word_cntr[3:0];
  assign w_accept  = data_valid_i && (r_state == ABSORB);
  assign w_nbytes  = !data_last_i ? 3'd4 : ((data_bytes_i > 3'd4) ? 3'd4 : data_bytes_i);
  assign w_wr_word = data_last_i ? pad_last_word(data_i, w_nbytes) : data_i;
  assign w_len_inc = {{(LenWidth-6){1'b0}}, w_nbytes, 3'b000};
  assign busy_o    = (r_state != ABSORB) || (r_word_cntr != 5'd0) || (r_len != '0);
  assign state_o   = r_state;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ABSORB;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    data_ready_o  = 1'b0;
    block_valid_o = 1'b0;
    block_last_o  = 1'b0;
    case (r_state)
      ABSORB: begin
        data_ready_o = 1'b1;
        if (w_accept) begin
          if (data_last_i)                w_state_nxt = PAD;
          else if (r_word_cntr == 5'd15)  w_state_nxt = EMIT;
        end
      end
      PAD: begin
        if (r_word_cntr == 5'd16)       w_state_nxt = EMIT;
        else if (r_pad80_pending)       w_state_nxt = PAD;
        else if (r_word_cntr <= 5'd14)  w_state_nxt = EMIT_LAST;
      end
      EMIT: begin
        block_valid_o = 1'b1;
        if (block_ready_i) w_state_nxt = r_padding_q ? PAD : ABSORB;
      end
      EMIT_LAST: begin
        block_valid_o = 1'b1;
        block_last_o  = 1'b1;
        if (block_ready_i) w_state_nxt = ABSORB;
      end
      default: w_state_nxt = ABSORB;
    endcase
  end

  // Datapath: each PAD cycle performs exactly one of the prioritised padding actions.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < BlockWords; i++) r_buf[i] <= '0;
      r_word_cntr     <= '0;
      r_len           <= '0;
      r_pad80_pending <= 1'b0;
      r_padding_q     <= 1'b0;
    end else begin
      case (r_state)
        ABSORB: begin
          if (w_accept) begin
            r_buf[w_idx] <= w_wr_word;
            r_word_cntr  <= r_word_cntr + 5'd1;
            r_len        <= r_len + w_len_inc;
            if (data_last_i) begin
              r_padding_q     <= 1'b1;
              r_pad80_pending <= (w_nbytes == 3'd4);
            end
          end
        end
        PAD: begin
          if (r_word_cntr == 5'd16) begin
            r_word_cntr <= r_word_cntr;
          end else if (r_pad80_pending) begin
            r_buf[w_idx]    <= PadWord;
            r_word_cntr     <= r_word_cntr + 5'd1;
            r_pad80_pending <= 1'b0;
          end else if (r_word_cntr <= 5'd14) begin
            r_buf[14] <= r_len[63:32];
            r_buf[15] <= r_len[31:0];
          end else begin
            r_word_cntr <= r_word_cntr + 5'd1;
          end
        end
        EMIT: begin
          if (block_ready_i) begin
            for (int i = 0; i < BlockWords; i++) r_buf[i] <= '0;
            r_word_cntr <= '0;
          end
        end
        EMIT_LAST: begin
          if (block_ready_i) begin
            for (int i = 0; i < BlockWords; i++) r_buf[i] <= '0;
            r_word_cntr <= '0;
            r_len       <= '0;
            r_padding_q <= 1'b0;
          end
        end
        default: r_word_cntr <= '0;
      endcase
    end
  end

  always_comb begin
    block_o = '0;
    for (int i = 0; i < BlockWords; i++)
      block_o[BlockWidth-1-WordWidth*i -: WordWidth] = r_buf[i];
  end

endmodule
